// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with timeout.
// Define ARB_ROUND_ROBIN_EN to alternate owners on contention.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [24:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [24:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_nbytes,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_start,
  output logic [24:0] mem_addr,
  output logic [2:0]  mem_nbytes,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            own_d;
  logic            grant_d;
  logic            timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic            last_d;
  assign grant_d = d_req && (!f_req || !last_d);
`else
  assign grant_d = d_req;
`endif

  assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      own_d      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d     <= 1'b0;
`endif
      mem_start  <= 1'b0;
      mem_addr   <= '0;
      mem_nbytes <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            own_d     <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= grant_d;
`endif
            mem_start <= 1'b1;
            cnt       <= '0;
            state     <= BUSY;
            if (grant_d) begin
              mem_addr   <= d_addr;
              mem_nbytes <= d_nbytes;
              mem_we     <= d_we;
              mem_wdata  <= d_wdata;
            end else begin
              mem_addr   <= f_addr;
              mem_nbytes <= 3'd4;
              mem_we     <= 1'b0;
              mem_wdata  <= '0;
            end
          end
        end
        BUSY: begin
          // mem_done wins over a coincident timeout
          if (mem_done) begin
            if (own_d) d_rdata <= mem_rdata;
            else       f_rdata <= mem_rdata;
            d_ack     <= own_d;
            f_ack     <= !own_d;
            mem_start <= 1'b0;
            state     <= RELEASE;
          end else if (timeout_hit) begin
            d_ack     <= own_d;
            f_ack     <= !own_d;
            err       <= 1'b1;
            mem_start <= 1'b0;
            state     <= RELEASE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (!mem_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: max cycles a granted transfer may wait for mem_done.
REQ-002 SHALL have ports clk (in, 1: clock) and rst (in, 1: reset). There is one clock; reset is synchronous and active-high.
REQ-003 SHALL have fetch port: f_req in 1, f_addr in 25, f_ack out 1, f_rdata out 32. Fetch is always a 4-byte read.
REQ-004 SHALL have data port: d_req in 1, d_addr in 25, d_we in 1, d_wdata in 32, d_nbytes in 3, d_ack out 1, d_rdata out 32.
REQ-005 SHALL have memory port: mem_start out 1, mem_addr out 25, mem_nbytes out 3, mem_we out 1, mem_wdata out 32, mem_rdata in 32, mem_done in 1.
REQ-006 SHALL have status outputs: busy out 1 (state != IDLE) and err out 1 (timeout pulse).

Function
REQ-007 SHALL implement states IDLE, BUSY and RELEASE, held in a registered state variable.
REQ-008 IDLE: when f_req or d_req is sampled high, SHALL select an owner per REQ-014/REQ-015.
- On that same edge: register the owner's address, nbytes, we and wdata onto the mem_* outputs; set mem_start=1; go to BUSY.
REQ-009 For a fetch grant, SHALL drive mem_nbytes=4, mem_we=0 and mem_wdata=0.
REQ-010 BUSY: when mem_done is sampled high, SHALL:
- latch mem_rdata into the owner's rdata register;
- pulse the owner's ack high for exactly one cycle;
- clear mem_start and go to RELEASE.
REQ-011 Owner rdata SHALL be updated only on its ack and SHALL hold otherwise. Rdata on a write ack is the latched mem_rdata and is don't-care to requesters.
REQ-012 RELEASE: SHALL stay until mem_done is sampled low, then go to IDLE. Requests are not sampled in RELEASE.
REQ-013 Requesters SHALL hold req and operands stable until ack and drop req on the edge ack is seen. A req still high in IDLE afterwards is a new request.
REQ-014 Without ARB_ROUND_ROBIN_EN: when both requests are present, data SHALL win (fixed priority).
REQ-015 A lone requester SHALL always be granted immediately, irrespective of arbitration mode.
REQ-016 Latency: mem_start SHALL rise 1 cycle after req is sampled. Ack SHALL rise 1 cycle after mem_done is sampled high. Minimum gap between back-to-back grants is 1 RELEASE cycle.
REQ-017 BUSY SHALL run a cycle counter cleared on grant. If the counter reaches TIMEOUT_CYCLES-1 with mem_done low, SHALL:
- pulse the owner's ack and err together for one cycle;
- leave rdata unchanged;
- clear mem_start and go to RELEASE.
REQ-018 The counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL saturate, never wrap.
REQ-019 If mem_done and the timeout occur in the same cycle, mem_done SHALL take precedence and err stays 0.
REQ-020 f_ack and d_ack SHALL never be high in the same cycle. mem_start SHALL never be high outside BUSY.
REQ-021 mem_addr, mem_nbytes, mem_we and mem_wdata SHALL be stable for the entire BUSY state.

Reset
REQ-022 On rst high at a clk edge:
- state=IDLE, counter=0, round-robin pointer=fetch;
- mem_start=0, mem_addr=0, mem_nbytes=0, mem_we=0, mem_wdata=0;
- f_ack=0, d_ack=0, err=0, busy=0, f_rdata=0, d_rdata=0.
REQ-023 Reset mid-transfer SHALL abandon the transfer with no ack and no err. rst SHALL take precedence over all other inputs.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN defined: on contention, grant the requester not granted last.
- A 1-bit last-owner register tracks this, updated on every grant.
- After reset, data wins the first contention.
REQ-025 Macro ARB_ROUND_ROBIN_EN undefined: fixed data priority per REQ-014, with no last-owner register present.

Verification
REQ-026 Single fetch: f_req=1, f_addr=0x000010; mem_done rises 5 cycles after mem_start with mem_rdata=0x00A00093.
- Required: mem_addr=0x000010, mem_nbytes=4, mem_we=0.
- Required: f_ack pulses once, f_rdata=0x00A00093, err=0.
REQ-027 Data write: d_req=1, d_we=1, d_addr=0x1000004, d_wdata=0xDEADBEEF, d_nbytes=4.
- Required: mem_we=1, mem_wdata=0xDEADBEEF, mem_addr=0x1000004.
- Required: d_ack pulses once; f_ack stays 0.
REQ-028 Contention, f_req and d_req high together for 3 transfers:
- macro off: order data, data, data while d_req is re-raised each time;
- macro on, both held high: order data, fetch, data.
REQ-029 Timeout with TIMEOUT_CYCLES=8 and mem_done held low:
- required: ack+err pulse 8 cycles after mem_start rose;
- required: mem_start=0, rdata unchanged, return to IDLE.
REQ-030 Reset mid-BUSY: rst=1 for 1 cycle at cycle 3 of BUSY.
- Required next cycle: mem_start=0, busy=0, no ack.
- A following f_req is served normally.
